// File: rtl/rf_alu.sv
// rtl/rf_alu.sv - 32x32 register file fused with a 32-bit ALU and status flags
// Optional: define RF_ALU_FLAG_REG_EN to register ZF/CF/OF/SF/PF on ALU write-back edges.
module rf_alu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Write_Reg,
  input  logic              Write_Select,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] Input_Data,
  input  logic [3:0]        OP,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic [DATA_W-1:0] ALU_F,
  output logic              ZF,
  output logic              CF,
  output logic              OF,
  output logic              SF,
  output logic              PF,
  output logic [DATA_W-1:0] W_Data
);

  localparam int NREG = 1 << ADDR_W;
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic              cf_c, of_c, zf_c, sf_c, pf_c;

  // Address 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (Write_Reg && (W_Addr != '0)) begin
      regs[W_Addr] <= W_Data;
    end
  end

  assign R_Data_A = (R_Addr_A == '0) ? '0 : regs[R_Addr_A];
  assign R_Data_B = (R_Addr_B == '0) ? '0 : regs[R_Addr_B];

  assign op_a = R_Data_A;
  assign op_b = R_Data_B;

  // One extra bit captures carry-out on add and borrow on subtract.
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    ALU_F = '0;
    cf_c  = 1'b0;
    of_c  = 1'b0;
    case (OP)
      OP_AND: ALU_F = op_a & op_b;
      OP_OR:  ALU_F = op_a | op_b;
      OP_XOR: ALU_F = op_a ^ op_b;
      OP_NOR: ALU_F = ~(op_a | op_b);
      OP_ADD: begin
        ALU_F = sum_ext[MSB:0];
        cf_c  = sum_ext[DATA_W];
        of_c  = (op_a[MSB] == op_b[MSB]) && (sum_ext[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        ALU_F = diff_ext[MSB:0];
        cf_c  = diff_ext[DATA_W];
        of_c  = (op_a[MSB] != op_b[MSB]) && (diff_ext[MSB] != op_a[MSB]);
      end
      OP_SLT: ALU_F = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL: ALU_F = op_b << op_a[SH_W-1:0];
      default: ALU_F = '0;
    endcase
  end

  assign zf_c = (ALU_F == '0);
  assign sf_c = ALU_F[MSB];
  assign pf_c = ~(^ALU_F);

  assign W_Data = Write_Select ? Input_Data : ALU_F;

`ifdef RF_ALU_FLAG_REG_EN
  logic [4:0] flags_q;

  // Flags only capture on edges that write an ALU result back.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      flags_q <= '0;
    end else if (Write_Reg && !Write_Select) begin
      flags_q <= {zf_c, cf_c, of_c, sf_c, pf_c};
    end
  end

  assign {ZF, CF, OF, SF, PF} = flags_q;
`else
  assign ZF = zf_c;
  assign CF = cf_c;
  assign OF = of_c;
  assign SF = sf_c;
  assign PF = pf_c;
`endif

endmodule

// File: tb/tb_rf_alu.sv
// tb/tb_rf_alu.sv - directed self-checking bench for rf_alu
// Flag expectations assume the default build (combinational flags).
module tb_rf_alu;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        Write_Reg = 1'b0;
  logic        Write_Select = 1'b0;
  logic [4:0]  R_Addr_A = '0;
  logic [4:0]  R_Addr_B = '0;
  logic [4:0]  W_Addr = '0;
  logic [31:0] Input_Data = '0;
  logic [3:0]  OP = '0;
  logic [31:0] R_Data_A, R_Data_B, ALU_F, W_Data;
  logic        ZF, CF, OF, SF, PF;

  int checks = 0;
  int errors = 0;

  rf_alu #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Clr(Clr), .Write_Reg(Write_Reg), .Write_Select(Write_Select),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
    .Input_Data(Input_Data), .OP(OP),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .ALU_F(ALU_F),
    .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .PF(PF), .W_Data(W_Data)
  );

  always #5 Clk = ~Clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flag vector order: {ZF, CF, OF, SF, PF}
  task automatic chkf(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {ZF, CF, OF, SF, PF};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s flags(ZCOSP) observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    Write_Select = 1'b1;
    Input_Data   = data;
    W_Addr       = addr;
    Write_Reg    = 1'b1;
    @(posedge Clk);
    #1;
    Write_Reg    = 1'b0;
  endtask

  task automatic sel(input logic [4:0] a, input logic [4:0] b, input logic [3:0] op);
    R_Addr_A = a;
    R_Addr_B = b;
    OP       = op;
    #1;
  endtask

  initial begin
    // Reset state
    sel(5'd1, 5'd2, 4'b0100);
    chk32("rst_rda", R_Data_A, 32'd0);
    chk32("rst_rdb", R_Data_B, 32'd0);
    chk32("rst_f", ALU_F, 32'd0);
    chkf("rst_flags", 5'b10001);

    // Write attempt while in reset is blocked
    Write_Select = 1'b1; Input_Data = 32'h55; W_Addr = 5'd1; Write_Reg = 1'b1;
    @(posedge Clk); #1;
    Write_Reg = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    #1;
    chk32("rst_blocks_wr", R_Data_A, 32'd0);

    // Clr mid-operation
    wr(5'd1, 32'd7);
    sel(5'd1, 5'd0, 4'b0100);
    chk32("pre_clr_r1", R_Data_A, 32'd7);
    #2 Clr = 1'b0;
    #1;
    chk32("async_clr_r1", R_Data_A, 32'd0);
    #1 Clr = 1'b1;
    @(negedge Clk);
    wr(5'd1, 32'd7);
    chk32("post_clr_r1", R_Data_A, 32'd7);

    wr(5'd2, 32'd4);
    sel(5'd1, 5'd2, 4'b0100);
    chk32("r1", R_Data_A, 32'd7);
    chk32("r2", R_Data_B, 32'd4);

    // ADD 7+4 with write-back to R3; no bypass before the edge
    chk32("add_f", ALU_F, 32'd11);
    chkf("add_flags", 5'b00000);
    Write_Select = 1'b0; W_Addr = 5'd3; Write_Reg = 1'b1;
    #1;
    chk32("wdata_alu", W_Data, 32'd11);
    R_Addr_B = 5'd3;
    #1;
    chk32("no_bypass", R_Data_B, 32'd0);
    R_Addr_B = 5'd2;
    @(posedge Clk); #1;
    Write_Reg = 1'b0;
    sel(5'd3, 5'd2, 4'b0100);
    chk32("wb_r3", R_Data_A, 32'd11);

    sel(5'd1, 5'd2, 4'b0101);
    chk32("sub_f", ALU_F, 32'd3);
    chkf("sub_flags", 5'b00001);
    sel(5'd1, 5'd2, 4'b0001);
    chk32("or_f", ALU_F, 32'd7);
    chkf("or_flags", 5'b00000);
    sel(5'd1, 5'd2, 4'b0010);
    chk32("xor_f", ALU_F, 32'd3);
    sel(5'd1, 5'd2, 4'b0111);
    chk32("sll_f", ALU_F, 32'd512);
    chkf("sll_flags", 5'b00000);
    sel(5'd1, 5'd2, 4'b0000);
    chk32("and_f", ALU_F, 32'd4);
    sel(5'd1, 5'd2, 4'b0011);
    chk32("nor_f", ALU_F, 32'hFFFF_FFF8);
    chkf("nor_flags", 5'b00010);
    sel(5'd1, 5'd2, 4'b0110);
    chk32("slt_f", ALU_F, 32'd0);
    chkf("slt_flags", 5'b10001);

    // Signed overflow and borrow
    wr(5'd4, 32'h7FFF_FFFF);
    wr(5'd5, 32'd1);
    sel(5'd4, 5'd5, 4'b0100);
    chk32("ovf_f", ALU_F, 32'h8000_0000);
    chkf("ovf_flags", 5'b00110);
    sel(5'd2, 5'd1, 4'b0101);
    chk32("borrow_f", ALU_F, 32'hFFFF_FFFD);
    chkf("borrow_flags", 5'b01010);
    sel(5'd2, 5'd1, 4'b0110);
    chk32("slt_true", ALU_F, 32'd1);

    // Carry out with no signed overflow: 0xFFFFFFFF + 1
    wr(5'd6, 32'hFFFF_FFFF);
    sel(5'd6, 5'd5, 4'b0100);
    chk32("carry_f", ALU_F, 32'd0);
    chkf("carry_flags", 5'b11001);

    // R0 is hardwired zero; reserved opcodes give 0
    wr(5'd0, 32'hFFFF_FFFF);
    sel(5'd0, 5'd1, 4'b1010);
    chk32("r0_zero", R_Data_A, 32'd0);
    chk32("op1010_f", ALU_F, 32'd0);
    chkf("op1010_flags", 5'b10001);
    sel(5'd1, 5'd2, 4'b1111);
    chk32("op1111_f", ALU_F, 32'd0);

    Write_Select = 1'b1; Input_Data = 32'hA5A5_0001;
    #1;
    chk32("wdata_input", W_Data, 32'hA5A5_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_alu.md
Name: rf_alu

Overview:
- 32-entry × 32-bit register file with two combinational read ports and one synchronous write port, fused with a 32-bit ALU.
- Read port A and read port B feed ALU operands A and B.
- Write data is either an external input word or the ALU result, chosen by Write_Select.
- Serves as the datapath core (register file + execute stage) of the single-cycle teaching CPU.

Parameters:
DATA_W, 32, register and ALU data width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
Clk  input  1  system clock; writes on rising edge
Clr  input  1  asynchronous active-low reset; clears all registers
Write_Reg  input  1  register write enable
Write_Select  input  1  write-data select: 1 = Input_Data, 0 = ALU_F
R_Addr_A  input  ADDR_W  read address, port A
R_Addr_B  input  ADDR_W  read address, port B
W_Addr  input  ADDR_W  write address
Input_Data  input  DATA_W  external write data
OP  input  4  ALU opcode
R_Data_A  output  DATA_W  register[R_Addr_A], combinational
R_Data_B  output  DATA_W  register[R_Addr_B], combinational
ALU_F  output  DATA_W  ALU result
ZF  output  1  zero flag
CF  output  1  carry/borrow flag
OF  output  1  signed overflow flag
SF  output  1  sign flag
PF  output  1  parity flag
W_Data  output  DATA_W  selected write data

Behaviour:
- Reset: Clr low clears all registers to 0 asynchronously, regardless of Clk. While Clr is low, writes are blocked. R_Data_A/B read 0, so ALU outputs follow from A=B=0.
- Write: on rising Clk with Clr high and Write_Reg=1, reg[W_Addr] <= W_Data.
- Register 0: hardwired zero; writes to address 0 are ignored.
- Read: R_Data_A/B are asynchronous reads. When the read address equals W_Addr in a write cycle, the read returns the old value until the edge; no bypass.
- W_Data = Write_Select ? Input_Data : ALU_F.
- ALU operands: A = R_Data_A, B = R_Data_B.
- Opcodes:
  - 0000 A & B
  - 0001 A | B
  - 0010 A ^ B
  - 0011 ~(A | B)
  - 0100 A + B
  - 0101 A − B
  - 0110 signed A < B ? 1 : 0
  - 0111 B << A[4:0]
  - 1000–1111: F = 0
- Flags, combinational from the current F:
  - ZF = (F == 0).
  - SF = F[31].
  - PF = XNOR-reduction of F (1 when F has an even number of ones).
  - CF: add = carry out of bit 31; sub = borrow (1 when unsigned A < B); otherwise 0.
  - OF: add = operands same sign and result sign differs; sub = operand signs differ and result sign differs from A; otherwise 0.
- Latency: read → ALU_F/flags is purely combinational. A result written back is visible on the read ports after the next rising edge.
- Simultaneous Clr low and write: reset wins.

Optional Feature:
- Macro RF_ALU_FLAG_REG_EN.
- Defined:
  - ZF/CF/OF/SF/PF are registered.
  - They load the combinational flags on a rising Clk when Write_Reg=1 and Write_Select=0; otherwise they hold.
  - They clear to 0 on Clr low.
  - ALU_F remains combinational.
- Undefined: flags are combinational as in Behaviour.

Test Plan:
- Clr low mid-operation after writing R1 → all reads 0 immediately; Clr high, write 7 → read back 7 next cycle.
- Write 7 to R1, then 4 to R2 (Write_Select=1, Write_Reg=1) → R_Data_A=7, R_Data_B=4 when addressing 1, 2.
- A=R1, B=R2 with OP sequence:
  - OP=0100 → F=11, ZF0 CF0 OF0 SF0 PF0; write-back to R3 reads 11.
  - OP=0101 → F=3, PF1, CF0.
  - OP=0001 → F=7, PF0.
  - OP=0010 → F=3.
  - OP=0111 → F=512, PF0.
- A=0x7FFFFFFF, B=1, OP=0100 → F=0x80000000, OF1 SF1 CF0 ZF0. A=4, B=7, OP=0101 → F=0xFFFFFFFD, CF1 SF1.
- Write to address 0 with Input_Data=0xFFFFFFFF → R0 still reads 0. OP=1010 → F=0, ZF1 PF1.
- With RF_ALU_FLAG_REG_EN defined: flags change only on qualifying edges and hold while Write_Select=1.
